// File: rtl/zbt_pkg.sv
// Shared widths, grant encoding and write-request payload for the ZBT request scheduler.
package zbt_pkg;

    localparam int unsigned ZBT_AW     = 19;
    localparam int unsigned ZBT_DW     = 36;
    localparam int unsigned ZBT_RD_LAT = 3;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

    typedef struct packed {
        logic [ZBT_AW-1:0] addr;
        logic [ZBT_DW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/zbt_req_sched_if.sv
// Request/return channels plus the driver-facing ZBT signals of the scheduler.
interface zbt_req_sched_if #(
    parameter int unsigned WF_DEPTH = 4,
    parameter int unsigned TAG_W    = 2
);
    localparam int unsigned LVL_W = $clog2(WF_DEPTH) + 1;

    logic                          wr_valid;
    logic                          wr_ready;
    logic [zbt_pkg::ZBT_AW-1:0]    wr_addr;
    logic [zbt_pkg::ZBT_DW-1:0]    wr_data;
    logic                          rd_valid;
    logic                          rd_ready;
    logic [zbt_pkg::ZBT_AW-1:0]    rd_addr;
    logic [TAG_W-1:0]              rd_tag;
    logic                          rdata_valid;
    logic [zbt_pkg::ZBT_DW-1:0]    rdata;
    logic [TAG_W-1:0]              rdata_tag;
    logic                          zbt_cen;
    logic                          zbt_we;
    logic [zbt_pkg::ZBT_AW-1:0]    zbt_addr;
    logic [zbt_pkg::ZBT_DW-1:0]    zbt_wdata;
    logic [zbt_pkg::ZBT_DW-1:0]    zbt_rdata;
    logic [LVL_W-1:0]              wf_level;

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rd_tag, zbt_rdata,
        output wr_ready, rd_ready, rdata_valid, rdata, rdata_tag,
               zbt_cen, zbt_we, zbt_addr, zbt_wdata, wf_level
    );

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rd_tag, zbt_rdata,
        input  wr_ready, rd_ready, rdata_valid, rdata, rdata_tag,
               zbt_cen, zbt_we, zbt_addr, zbt_wdata, wf_level
    );

endinterface

// File: rtl/zbt_wfifo.sv
// Write-request FIFO that also reports whether any queued entry targets a given address.
module zbt_wfifo
    import zbt_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  wr_req_t                  push_req,
    input  logic                     pop,
    input  logic [ZBT_AW-1:0]        cmp_addr,
    output wr_req_t                  head_c,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full_c,
    output logic                     empty_c,
    output logic                     hit_c
);

    localparam int unsigned PW    = $clog2(DEPTH);
    localparam int unsigned LVL_W = PW + 1;

    wr_req_t            mem [DEPTH];
    logic [DEPTH-1:0]   vld;
    logic [DEPTH-1:0]   vld_nxt;
    logic [DEPTH-1:0]   hit_vec;
    logic [PW-1:0]      wptr;
    logic [PW-1:0]      rptr;

    assign head_c  = mem[rptr];
    assign full_c  = (level == LVL_W'(DEPTH));
    assign empty_c = (level == '0);
    assign hit_c   = |hit_vec;

    // Entry valid bits follow push/pop so the compare ignores stale slots.
    always_comb begin
        vld_nxt = vld;
        if (pop)
            vld_nxt[rptr] = 1'b0;
        if (push)
            vld_nxt[wptr] = 1'b1;
    end

    always_comb begin
        hit_vec = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            hit_vec[i] = vld[i] && (mem[i].addr == cmp_addr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
            vld   <= '0;
        end else begin
            vld <= vld_nxt;
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= push_req;
    end

endmodule

// File: rtl/zbt_req_sched.sv
// Merges a queued write stream and a read stream into one ZBT driver request per clock,
// holding reads behind same-address writes and returning tagged read data in order.
module zbt_req_sched
    import zbt_pkg::*;
#(
    parameter int unsigned WF_DEPTH     = 4,
    parameter int unsigned TAG_W        = 2,
    parameter int unsigned WR_BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    zbt_req_sched_if.slave   bus
);

    localparam int unsigned LVL_W = $clog2(WF_DEPTH) + 1;
    localparam int unsigned SC_W  = $clog2(WR_BURST_MAX + 1);

    wr_req_t                          head;
    wr_req_t                          push_req;
    logic [LVL_W-1:0]                 level;
    logic                             full;
    logic                             empty;
    logic                             fifo_hit;
    logic                             push;
    logic                             pop;
    logic                             rd_hit;
    logic                             starved;
    gnt_e                             gnt;
    logic [SC_W-1:0]                  starve_cnt;
    logic                             h1_v;
    logic [ZBT_AW-1:0]                h1_addr;
    logic [ZBT_RD_LAT-1:0]            pv;
    logic [ZBT_RD_LAT-1:0][TAG_W-1:0] pt;

    assign push_req      = '{addr: bus.wr_addr, data: bus.wr_data};
    assign bus.wr_ready  = !reset && !full;
    assign push          = bus.wr_valid && bus.wr_ready;
    assign pop           = (gnt == GNT_WR);
    assign bus.rd_ready  = (gnt == GNT_RD);
    assign bus.wf_level  = level;

    zbt_wfifo #(.DEPTH(WF_DEPTH)) u_wfifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_req (push_req),
        .pop      (pop),
        .cmp_addr (bus.rd_addr),
        .head_c   (head),
        .level    (level),
        .full_c   (full),
        .empty_c  (empty),
        .hit_c    (fifo_hit)
    );

    // zbt_we/zbt_addr double as the first write-history slot; h1 holds the one before.
    always_comb begin
        rd_hit  = fifo_hit
               || (bus.zbt_we && (bus.zbt_addr == bus.rd_addr))
               || (h1_v && (h1_addr == bus.rd_addr));
        starved = !empty && (starve_cnt == SC_W'(WR_BURST_MAX));
        gnt     = GNT_IDLE;
        if (!reset) begin
            if (bus.rd_valid && !rd_hit && !starved)
                gnt = GNT_RD;
            else if (!empty)
                gnt = GNT_WR;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.zbt_cen   <= 1'b0;
            bus.zbt_we    <= 1'b0;
            bus.zbt_addr  <= '0;
            bus.zbt_wdata <= '0;
            h1_v          <= 1'b0;
            h1_addr       <= '0;
            starve_cnt    <= '0;
        end else begin
            bus.zbt_cen <= 1'b1;
            bus.zbt_we  <= (gnt == GNT_WR);
            h1_v        <= bus.zbt_we;
            h1_addr     <= bus.zbt_addr;
            case (gnt)
                GNT_RD: bus.zbt_addr <= bus.rd_addr;
                GNT_WR: begin
                    bus.zbt_addr  <= head.addr;
                    bus.zbt_wdata <= head.data;
                end
                default: ;
            endcase
            if (empty || gnt == GNT_WR)
                starve_cnt <= '0;
            else if (gnt == GNT_RD)
                starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    // Read return: tag/valid ride the pipe while the driver fetches the data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv              <= '0;
            pt              <= '0;
            bus.rdata_valid <= 1'b0;
            bus.rdata       <= '0;
            bus.rdata_tag   <= '0;
        end else begin
            pv              <= {pv[ZBT_RD_LAT-2:0], (gnt == GNT_RD)};
            pt              <= {pt[ZBT_RD_LAT-2:0], bus.rd_tag};
            bus.rdata_valid <= pv[ZBT_RD_LAT-1];
            if (pv[ZBT_RD_LAT-1]) begin
                bus.rdata     <= bus.zbt_rdata;
                bus.rdata_tag <= pt[ZBT_RD_LAT-1];
            end
        end
    end

endmodule

// File: tb/tb_zbt_req_sched.sv
// Directed and random bench for zbt_req_sched with a RAM model standing in for the ZBT driver.
module tb_zbt_req_sched;
    import zbt_pkg::*;

    localparam int unsigned WF_DEPTH     = 4;
    localparam int unsigned TAG_W        = 2;
    localparam int unsigned WR_BURST_MAX = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [ZBT_DW-1:0]         ram    [1024];
    logic [ZBT_DW-1:0]         sb_mem [1024];
    logic [TAG_W+ZBT_DW-1:0]   exp_q  [$];
    logic                      rv1;
    logic [9:0]                ra1;

    zbt_req_sched_if #(.WF_DEPTH(WF_DEPTH), .TAG_W(TAG_W)) bus ();

    zbt_req_sched #(
        .WF_DEPTH     (WF_DEPTH),
        .TAG_W        (TAG_W),
        .WR_BURST_MAX (WR_BURST_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_valid = 1'b0;
        bus.rd_addr  = '0;
        bus.rd_tag   = '0;
    endtask

    // Driver model (command sampled one edge, data driven the next) plus in-order scoreboard.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            rv1 <= 1'b0;
            ra1 <= '0;
            for (int i = 0; i < 1024; i++) begin
                ram[i]    <= '0;
                sb_mem[i] <= '0;
            end
        end else begin
            if (rv1)
                bus.zbt_rdata <= ram[ra1];
            rv1 <= bus.zbt_cen && !bus.zbt_we;
            ra1 <= bus.zbt_addr[9:0];
            if (bus.zbt_cen && bus.zbt_we)
                ram[bus.zbt_addr[9:0]] <= bus.zbt_wdata;
            if (bus.rd_valid && bus.rd_ready)
                exp_q.push_back({bus.rd_tag, sb_mem[bus.rd_addr[9:0]]});
            if (bus.wr_valid && bus.wr_ready)
                sb_mem[bus.wr_addr[9:0]] <= bus.wr_data;
        end
    end

    always @(negedge clk) begin
        logic [TAG_W+ZBT_DW-1:0] e;
        if (bus.rdata_valid) begin
            chk("ret_pending", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("ret_tag",  64'(bus.rdata_tag), 64'(e[TAG_W+ZBT_DW-1:ZBT_DW]));
                chk("ret_data", 64'(bus.rdata),     64'(e[ZBT_DW-1:0]));
            end
        end
    end

    initial begin
        int  lvl_e;
        int  lvl_b;
        logic exp_rd;

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cen",      64'(bus.zbt_cen),     64'(0));
        chk("rst_we",       64'(bus.zbt_we),      64'(0));
        chk("rst_addr",     64'(bus.zbt_addr),    64'(0));
        chk("rst_level",    64'(bus.wf_level),    64'(0));
        chk("rst_rvalid",   64'(bus.rdata_valid), 64'(0));
        chk("rst_wr_ready", 64'(bus.wr_ready),    64'(0));
        reset = 1'b0;
        tick();
        chk("cen_after_rst", 64'(bus.zbt_cen), 64'(1));

        // Three queued writes drain in order with no reads present.
        for (int i = 0; i < 6; i++) begin
            bus.wr_valid = (i < 3);
            bus.wr_addr  = 19'(32'h10 + i);
            bus.wr_data  = 36'(32'hA + i);
            #1;
            chk("t1_wr_ready", 64'(bus.wr_ready), 64'(1));
            tick();
            chk("t1_we", 64'(bus.zbt_we), 64'(i >= 1 && i <= 3));
            if (i >= 1 && i <= 3) begin
                chk("t1_addr",  64'(bus.zbt_addr),  64'(32'h10 + i - 1));
                chk("t1_wdata", 64'(bus.zbt_wdata), 64'(32'hA + i - 1));
            end
            chk("t1_level", 64'(bus.wf_level), 64'((i < 3) ? 1 : 0));
        end
        idle_inputs();
        repeat (3) tick();

        // Back-to-back reads, returns three edges after each accept.
        for (int i = 0; i < 8; i++) begin
            bus.rd_valid = (i < 4);
            bus.rd_addr  = 19'(32'h10 + i);
            bus.rd_tag   = TAG_W'(i);
            #1;
            chk("t2_rd_ready", 64'(bus.rd_ready), 64'(i < 4));
            tick();
            chk("t2_rvalid", 64'(bus.rdata_valid), 64'(i >= 3 && i <= 6));
            if (i >= 3 && i <= 6) begin
                chk("t2_tag",  64'(bus.rdata_tag), 64'(i - 3));
                chk("t2_data", 64'(bus.rdata),     64'((i - 3 < 3) ? (32'hA + i - 3) : 0));
            end
        end
        idle_inputs();
        repeat (3) tick();

        // Read-after-write to the same address waits for the write plus two cycles.
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 19'h20;
        bus.wr_data  = 36'h55;
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 19'h20;
        bus.rd_tag   = 2'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_rd_ready", 64'(bus.rd_ready), 64'(k == 3));
            chk("t3_we",       64'(bus.zbt_we),   64'(k == 1));
            tick();
        end
        bus.rd_valid = 1'b0;
        tick();
        tick();
        chk("t3_rvalid_early", 64'(bus.rdata_valid), 64'(0));
        tick();
        chk("t3_rvalid", 64'(bus.rdata_valid), 64'(1));
        chk("t3_rdata",  64'(bus.rdata),       64'(36'h55));
        chk("t3_tag",    64'(bus.rdata_tag),   64'(2));
        idle_inputs();
        repeat (3) tick();

        // Full FIFO under continuous reads: a write is forced after every four read grants.
        lvl_e = 0;
        for (int c = 0; c < 22; c++) begin
            bus.wr_valid = (c < 6);
            bus.wr_addr  = 19'(32'h40 + ((c < 4) ? c : 4));
            bus.wr_data  = 36'(32'h100 + c);
            bus.rd_valid = 1'b1;
            bus.rd_addr  = 19'(32'h100 + c);
            bus.rd_tag   = TAG_W'(c);
            exp_rd = (c == 0) || (c % 5 != 0);
            #1;
            chk("t4_rd_ready", 64'(bus.rd_ready), 64'(exp_rd));
            chk("t4_level",    64'(bus.wf_level), 64'(lvl_e));
            chk("t4_wr_ready", 64'(bus.wr_ready), 64'(lvl_e != 4));
            tick();
            lvl_b = lvl_e;
            if (c < 6 && lvl_b != 4)
                lvl_e++;
            if (!exp_rd && lvl_b > 0)
                lvl_e--;
        end
        idle_inputs();
        repeat (6) tick();
        chk("t4_drained", 64'(bus.wf_level), 64'(0));

        // Reset with two writes queued and two reads in flight.
        bus.wr_valid = 1'b1; bus.wr_addr = 19'h200; bus.wr_data = 36'h1;
        bus.rd_valid = 1'b1; bus.rd_addr = 19'h300; bus.rd_tag = 2'd0;
        tick();
        bus.wr_addr = 19'h201; bus.wr_data = 36'h2;
        bus.rd_addr = 19'h301; bus.rd_tag = 2'd1;
        tick();
        idle_inputs();
        chk("t5_level_pre", 64'(bus.wf_level), 64'(2));
        reset = 1'b1;
        #1;
        chk("t5_level", 64'(bus.wf_level),    64'(0));
        chk("t5_we",    64'(bus.zbt_we),      64'(0));
        chk("t5_cen",   64'(bus.zbt_cen),     64'(0));
        chk("t5_rv",    64'(bus.rdata_valid), 64'(0));
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t5_no_return", 64'(bus.rdata_valid), 64'(0));
            chk("t5_we_idle",   64'(bus.zbt_we),      64'(0));
        end

        // Random mixed traffic on a small address window against the scoreboard.
        for (int n = 0; n < 10000; n++) begin
            bus.wr_valid = 1'($urandom_range(0, 1));
            bus.wr_addr  = 19'(32'h30 + $urandom_range(0, 7));
            bus.wr_data  = {4'($urandom), $urandom};
            bus.rd_valid = 1'($urandom_range(0, 1));
            bus.rd_addr  = 19'(32'h30 + $urandom_range(0, 7));
            bus.rd_tag   = TAG_W'($urandom);
            tick();
        end
        idle_inputs();
        repeat (12) tick();
        chk("rand_lost_returns", 64'(exp_q.size()), 64'(0));
        chk("rand_fifo_empty",   64'(bus.wf_level), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
